bounce_gen: RTL and testbench
=============================

BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 SHALL expose parameter ClkFreq, default 100_000_000, clock frequency in Hz; informational only, used for elaboration checks.
REQ-002 SHALL expose parameter MaxGapCycles, default 120, the largest number of cycles between bounce toggles; must be ≥1 and <65536.
REQ-003 SHALL expose parameter LfsrSeed, default 16'hACE1, the LFSR reset value; must be nonzero.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, the reset; it is synchronous and active-high.
REQ-006 SHALL have port start_i, input, 1 bit, the request to start one switch-press emulation.
REQ-007 SHALL have port level_i, input, 1 bit, the final settled level of sw_o.
REQ-008 SHALL have port bounces_i, input, 16 bits, the number of sw_o toggles before settling.
REQ-009 SHALL have port settle_i, input, 32 bits, the number of cycles sw_o is held at level before completion.
REQ-010 SHALL have port sw_o, output, 1 bit, the emulated bouncy switch signal that feeds a debouncer.
REQ-011 SHALL have port busy_o, output, 1 bit, high while an emulation is in progress.
REQ-012 SHALL have port done_o, output, 1 bit, a one-cycle pulse when an emulation completes.

Function
REQ-013 SHALL implement FSM states IDLE, BOUNCE and SETTLE; busy_o is high exactly when the state is not IDLE.
REQ-014 SHALL accept start_i only in IDLE; accepting start_i in cycle N latches level_i, bounces_i and settle_i.
REQ-015 SHALL ignore start_i while busy_o is high; a start_i held high is re-accepted in the first IDLE cycle.
REQ-016 SHALL, on acceptance with bounces_i=0, set sw_o to the latched level at N+1 and enter SETTLE.
REQ-017 SHALL, on acceptance with bounces_i>0, enter BOUNCE with sw_o unchanged and load the gap counter with gap = (lfsr mod MaxGapCycles)+1.
REQ-018 SHALL keep every gap in the range 1..MaxGapCycles.
REQ-019 SHALL, in BOUNCE, decrement the gap counter each cycle; when it expires, toggle sw_o, decrement the remaining-bounce count, and reload a new gap from the current LFSR value.
REQ-020 SHALL, after the last toggle's gap expires, drive sw_o to the latched level and enter SETTLE; sw_o then shows exactly bounces_i toggles plus at most one final correction edge.
REQ-021 SHALL, in SETTLE, hold sw_o at level for max(settle_i,1) cycles; in the following cycle it returns to IDLE, pulses done_o and drops busy_o.
REQ-022 SHALL implement the LFSR as 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle including IDLE, so it never reaches zero.
REQ-023 SHALL keep sw_o stable in IDLE, retaining its last value.
REQ-024 SHALL use saturation-free counters: 16-bit bounce, 16-bit gap, 32-bit settle.

Reset
REQ-025 SHALL, on rst_i high at a clock edge, force state IDLE, sw_o=0, busy_o=0, done_o=0, lfsr=LfsrSeed and all counters to 0.
REQ-026 SHALL let reset mid-emulation abort it immediately, with no done_o pulse.
REQ-027 SHALL give rst_i priority over a simultaneous start_i.

Structure
REQ-028 SHALL place the state enum, the LFSR width/taps constants and the counter widths in package bounce_gen_pkg.
REQ-029 SHALL instantiate one sub-module, lfsr16 (seed parameter, enable, state output).
REQ-030 SHALL fail elaboration when MaxGapCycles=0 or LfsrSeed=0.

Verification
REQ-031 SHALL cover: reset, then bounces_i=0, settle_i=5, level_i=1, start at N -> sw_o=1 at N+1, busy_o high N+1..N+5, done_o pulse at N+6 only.
REQ-032 SHALL cover: bounces_i=50, MaxGapCycles=120, settle_i=100 -> exactly 50 toggles, every inter-toggle gap in 1..120, final sw_o=level_i, one done_o.
REQ-033 SHALL cover: settle_i=0 -> treated as 1; done_o two cycles after start acceptance.
REQ-034 SHALL cover: start_i pulsed during BOUNCE -> ignored, toggle count unchanged, single done_o.
REQ-035 SHALL cover: rst_i asserted mid-BOUNCE -> next cycle sw_o=0, busy_o=0, no done_o; a new start proceeds normally.
REQ-036 SHALL cover: bounces_i=50 driving the debouncer with debounce_time=120 -> debouncer output changes once, to level_i.

Source files
------------

// File: rtl/bounce_gen_pkg.sv
// bounce_gen_pkg: shared state encoding, LFSR constants and counter widths for the bouncy-switch emulator.
package bounce_gen_pkg;
    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;
    localparam int LFSR_W = 16;
    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form: bits 0,2,3,5.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
    localparam int BOUNCE_W = 16;
    localparam int GAP_W = 16;
    localparam int SETTLE_W = 32;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction
endpackage

// File: rtl/bounce_gen_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR with loadable seed on reset.
module lfsr16
    import bounce_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] Seed = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);
    always_ff @(posedge clk) begin
        if (rst) state <= Seed;
        else if (en) state <= lfsr_next(state);
    end
endmodule

// File: rtl/bounce_gen.sv
// bounce_gen: emulates one bouncy switch press (random-gap toggles, then a settled level) for debouncer testing.
module bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter int unsigned       ClkFreq      = 100_000_000,
    parameter int unsigned       MaxGapCycles = 120,
    parameter logic [LFSR_W-1:0] LfsrSeed     = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                level_i,
    input  logic [BOUNCE_W-1:0] bounces_i,
    input  logic [SETTLE_W-1:0] settle_i,
    output logic                sw_o,
    output logic                busy_o,
    output logic                done_o
);
    if (MaxGapCycles == 0 || MaxGapCycles >= 65536 || LfsrSeed == '0 || ClkFreq == 0) begin : g_param_check
        $error("bounce_gen: MaxGapCycles must be 1..65535, LfsrSeed and ClkFreq nonzero");
    end

    localparam logic [GAP_W-1:0] MaxGap = GAP_W'(MaxGapCycles);

    state_t              state;
    logic                level_q;
    logic [BOUNCE_W-1:0] bounce_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [LFSR_W-1:0]   lfsr;
    logic [GAP_W-1:0]    new_gap;

    lfsr16 #(.Seed(LfsrSeed)) u_lfsr (
        .clk  (clk_i),
        .rst  (rst_i),
        .en   (1'b1),
        .state(lfsr)
    );

    assign new_gap = (lfsr % MaxGap) + GAP_W'(1);
    assign busy_o  = state != IDLE;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            sw_o       <= 1'b0;
            done_o     <= 1'b0;
            level_q    <= 1'b0;
            bounce_cnt <= '0;
            gap_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    level_q    <= level_i;
                    bounce_cnt <= bounces_i;
                    settle_cnt <= settle_i == '0 ? SETTLE_W'(1) : settle_i;
                    if (bounces_i == '0) begin
                        sw_o  <= level_i;
                        state <= SETTLE;
                    end else begin
                        gap_cnt <= new_gap;
                        state   <= BOUNCE;
                    end
                end
                // A gap of g means the next edge lands g cycles after the previous one.
                BOUNCE: if (gap_cnt == GAP_W'(1)) begin
                    if (bounce_cnt != '0) begin
                        sw_o       <= ~sw_o;
                        bounce_cnt <= bounce_cnt - BOUNCE_W'(1);
                        gap_cnt    <= new_gap;
                    end else begin
                        sw_o  <= level_q;
                        state <= SETTLE;
                    end
                end else begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                end
                SETTLE: if (settle_cnt == SETTLE_W'(1)) begin
                    state  <= IDLE;
                    done_o <= 1'b1;
                end else begin
                    settle_cnt <= settle_cnt - SETTLE_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: directed presses checked against a waveform-plan model, plus hand-computed expectations.
module tb_bounce_gen;
    localparam int MaxGap = 120;
    localparam logic [15:0] Seed = 16'hACE1;
    localparam int DebTime = 120;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    logic level_i = 1'b0;
    logic [15:0] bounces_i = '0;
    logic [31:0] settle_i = '0;
    logic sw_o, busy_o, done_o;
    int checks = 0;
    int failures = 0;

    bounce_gen #(.ClkFreq(100_000_000), .MaxGapCycles(MaxGap), .LfsrSeed(Seed)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .level_i  (level_i),
        .bounces_i(bounces_i),
        .settle_i (settle_i),
        .sw_o     (sw_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Model: on acceptance, lay out the whole expected {sw,busy,done} waveform cycle by cycle.
    logic [2:0] plan[$];
    logic [2:0] cur = '0;
    logic [15:0] lm = Seed;
    bit model_on = 0;

    function automatic logic [15:0] lnext(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    task automatic build(input logic s0, input logic lvl, input int nb, input int st, input logic [15:0] l0);
        logic s;
        logic [15:0] l;
        int g;
        s = s0;
        l = l0;
        if (nb > 0) begin
            for (int i = 0; i <= nb; i++) begin
                g = int'(l) % MaxGap + 1;
                repeat (g) begin
                    plan.push_back({s, 2'b10});
                    l = lnext(l);
                end
                if (i < nb) s = ~s;
            end
        end
        repeat (st == 0 ? 1 : st) plan.push_back({lvl, 2'b10});
        plan.push_back({lvl, 2'b01});
    endtask

    initial forever begin
        @(posedge clk_i);
        if (rst_i) begin
            plan.delete();
            cur = '0;
            lm = Seed;
            model_on = 1;
        end else begin
            if (!cur[1] && start_i) build(cur[2], level_i, int'(bounces_i), int'(settle_i), lm);
            if (plan.size() > 0) cur = plan.pop_front();
            else cur = {cur[2], 2'b00};
            lm = lnext(lm);
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (model_on && !rst_i)
            check($sformatf("cycle@%0t sw/busy/done", $time), {29'd0, sw_o, busy_o, done_o}, {29'd0, cur});
    end

    // Reference debouncer: follows sw_o only after it has been stable for DebTime samples.
    logic deb = 1'b0;
    logic prev_sw = 1'b0;
    int stab = 0;
    int deb_changes = 0;
    initial forever begin
        @(negedge clk_i);
        if (sw_o !== prev_sw) stab = 0;
        else if (stab < 100000) stab++;
        prev_sw = sw_o;
        if (stab >= DebTime && deb !== sw_o) begin
            deb = sw_o;
            deb_changes++;
        end
    end

    task automatic press(input logic lvl, input int nb, input int st, input int pa, input int pb,
                         output int edges, output int dones, output int first, output int gmax);
        logic prev;
        int last;
        prev = sw_o;
        edges = 0;
        dones = 0;
        first = 0;
        gmax = 0;
        last = 0;
        level_i = lvl;
        bounces_i = 16'(nb);
        settle_i = 32'(st);
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        for (int i = 1; i < 20000; i++) begin
            @(negedge clk_i);
            if (sw_o !== prev) begin
                if (edges == 0) first = i;
                else if (i - last > gmax) gmax = i - last;
                edges++;
                last = i;
                prev = sw_o;
            end
            if (done_o) begin
                dones++;
                break;
            end
            @(posedge clk_i);
            #1 start_i = (i == pa || i == pb);
        end
        start_i = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int e, d, f, gm;
        logic [6:0] bv, dv, sv;
        logic [2:0] bv3, dv3, sv3;
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // First press right after reset: gap = 0xACE1 % 120 + 1 = 98, first edge 99 cycles after acceptance.
        press(1'b0, 1, 3, 0, 0, e, d, f, gm);
        check("t1_first_edge", f, 99);
        check("t1_edges", e, 2);
        check("t1_dones", d, 1);
        check("t1_final_sw", {31'd0, sw_o}, 0);

        level_i = 1'b1;
        bounces_i = 0;
        settle_i = 5;
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_i);
            bv[k] = busy_o;
            dv[k] = done_o;
            sv[k] = sw_o;
        end
        check("t2_busy_n1_n7", {25'd0, bv}, 32'b0011111);
        check("t2_done_n1_n7", {25'd0, dv}, 32'b0100000);
        check("t2_sw_n1_n7", {25'd0, sv}, 32'b1111111);
        @(posedge clk_i);
        #1;

        level_i = 1'b0;
        bounces_i = 0;
        settle_i = 0;
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            bv3[k] = busy_o;
            dv3[k] = done_o;
            sv3[k] = sw_o;
        end
        check("t3_busy_n1_n3", {29'd0, bv3}, 32'b001);
        check("t3_done_n1_n3", {29'd0, dv3}, 32'b010);
        check("t3_sw_n1_n3", {29'd0, sv3}, 32'b000);
        repeat (150) @(posedge clk_i);
        #1;

        deb_changes = 0;
        press(1'b1, 50, 100, 0, 0, e, d, f, gm);
        check("t4_edges_50_plus_fix", e, 51);
        check("t4_gap_le_max", {31'd0, gm <= MaxGap}, 1);
        check("t4_dones", d, 1);
        check("t4_final_sw", {31'd0, sw_o}, 1);
        repeat (200) @(posedge clk_i);
        #1;
        check("t4_deb_changes", deb_changes, 1);
        check("t4_deb_level", {31'd0, deb}, 1);

        press(1'b0, 20, 10, 30, 60, e, d, f, gm);
        check("t5_edges_ignore_start", e, 21);
        check("t5_dones", d, 1);
        check("t5_final_sw", {31'd0, sw_o}, 0);

        level_i = 1'b1;
        bounces_i = 30;
        settle_i = 10;
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (40) @(posedge clk_i);
        @(negedge clk_i);
        check("t6_busy_before_reset", {31'd0, busy_o}, 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        check("t6_after_reset", {29'd0, sw_o, busy_o, done_o}, 0);
        d = 0;
        repeat (50) begin
            @(negedge clk_i);
            if (done_o) d++;
        end
        check("t6_no_done", d, 0);
        @(posedge clk_i);
        #1;
        press(1'b1, 4, 3, 0, 0, e, d, f, gm);
        check("t6_new_edges", e, 5);
        check("t6_new_dones", d, 1);
        check("t6_new_final_sw", {31'd0, sw_o}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures + 1);
        $fatal(1, "watchdog");
    end
endmodule
